daco_controller: RTL

- Host-side issuer directly upstream of the DaCO overlay array.
- Accepts packets from the host over a valid/ready stream and buffers them in a command FIFO.
- Drives them one at a time onto controller2daco, waits for the overlay's ack with timeout/retry, and buffers packets returned on daco2controller into a result FIFO read by the host.

---
 rtl/daco_controller_pkg.sv | 35 +++
 rtl/daco_sync_fifo.sv | 51 +++++
 rtl/daco_controller.sv | 133 +++++++++++++
 3 files changed

// File: rtl/daco_controller_pkg.sv
// Shared definitions for the DaCO host-side controller.
// Packet layout: [63] valid, [62:61] dst_x, [60:59] dst_y, [58:56] opcode,
// [55:0] payload. Also holds the issue FSM state encoding and a packet builder.
package daco_controller_pkg;

    localparam int PACKET_W   = 64;
    localparam int VALID_BIT  = 63;
    localparam int DST_X_LSB  = 61;
    localparam int DST_Y_LSB  = 59;
    localparam int OPCODE_LSB = 56;
    localparam int PAYLOAD_W  = 56;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_SEND     = 2'd1,
        ST_WAIT_ACK = 2'd2
    } state_t;

    function automatic logic [PACKET_W-1:0] make_pkt(
        input logic [1:0]           dst_x,
        input logic [1:0]           dst_y,
        input logic [2:0]           opcode,
        input logic [PAYLOAD_W-1:0] payload
    );
        logic [PACKET_W-1:0] p;
        p                    = '0;
        p[VALID_BIT]         = 1'b1;
        p[DST_X_LSB +: 2]    = dst_x;
        p[DST_Y_LSB +: 2]    = dst_y;
        p[OPCODE_LSB +: 3]   = opcode;
        p[PAYLOAD_W-1:0]     = payload;
        return p;
    endfunction

endpackage

// File: rtl/daco_sync_fifo.sv
// Synchronous FIFO, power-of-two depth.
// Ports: clk, rst (async active-low), wr_en/wr_data, full, rd_en/rd_data, empty.
// A write while full is accepted when a read happens in the same cycle.
// rd_data shows the head combinationally and reads 0 while empty.
module daco_sync_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    output logic             full,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [DEPTH-1:0][WIDTH-1:0] mem;
    logic [AW-1:0]               wr_ptr, rd_ptr;
    logic [AW:0]                 count;
    logic                        do_wr, do_rd;

    assign empty   = (count == '0);
    assign full    = (count == (AW+1)'(DEPTH));
    assign do_rd   = rd_en && !empty;
    assign do_wr   = wr_en && (!full || do_rd);
    assign rd_data = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_wr) mem[wr_ptr] <= wr_data;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + 1'b1;
            if (do_rd) rd_ptr <= rd_ptr + 1'b1;
            case ({do_wr, do_rd})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/daco_controller.sv
// Host-side issuer for the DaCO overlay array.
// Ports: clk, rst (async active-low); cmd_* host command stream in;
// res_* result stream out to host; controller2daco / daco2controller /
// ack2controller overlay link; busy, err_drop, drop_cnt, ovf_cnt status;
// clr_err clears the sticky status.
// Commands are sent one at a time as a single-cycle valid pulse and re-sent
// on ack timeout; after MAX_RETRY re-sends the command is dropped.
module daco_controller
    import daco_controller_pkg::*;
#(
    parameter int PKT_W       = PACKET_W,
    parameter int CMD_DEPTH   = 8,
    parameter int RES_DEPTH   = 8,
    parameter int ACK_TIMEOUT = 32,
    parameter int MAX_RETRY   = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [PKT_W-1:0] cmd_data,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    output logic [PKT_W-1:0] res_data,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [PKT_W-1:0] controller2daco,
    input  logic [PKT_W-1:0] daco2controller,
    input  logic             ack2controller,
    output logic             busy,
    output logic             err_drop,
    output logic [7:0]       drop_cnt,
    output logic [7:0]       ovf_cnt,
    input  logic             clr_err
);
    localparam int TW = $clog2(ACK_TIMEOUT);
    localparam int RW = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);

    state_t           state_q, state_d;
    logic [TW-1:0]    timer_q;
    logic [RW-1:0]    retry_q;
    logic             ready_en;   // holds cmd_ready low until the first edge after reset
    logic             cmd_full, cmd_empty, cmd_pop, cmd_push;
    logic [PKT_W-1:0] cmd_head;
    logic             res_full, res_empty, res_pop, res_push;
    logic             timeout, retry_left, drop_evt, ovf_evt;

    assign cmd_ready  = ready_en && !cmd_full;
    assign cmd_push   = cmd_valid && cmd_ready;
    assign res_valid  = !res_empty;
    assign res_pop    = res_valid && res_ready;
    assign res_push   = daco2controller[PKT_W-1];
    assign ovf_evt    = res_push && res_full && !res_pop;
    assign busy       = (state_q != ST_IDLE) || !cmd_empty;
    assign timeout    = (timer_q == TW'(ACK_TIMEOUT - 1));
    assign retry_left = (retry_q < RW'(MAX_RETRY));

    daco_sync_fifo #(.WIDTH(PKT_W), .DEPTH(CMD_DEPTH)) u_cmd_fifo (
        .clk(clk), .rst(rst),
        .wr_en(cmd_push), .wr_data(cmd_data), .full(cmd_full),
        .rd_en(cmd_pop), .rd_data(cmd_head), .empty(cmd_empty)
    );

    daco_sync_fifo #(.WIDTH(PKT_W), .DEPTH(RES_DEPTH)) u_res_fifo (
        .clk(clk), .rst(rst),
        .wr_en(res_push), .wr_data(daco2controller), .full(res_full),
        .rd_en(res_pop), .rd_data(res_data), .empty(res_empty)
    );

    // Ack is checked before timeout so a coincident ack wins.
    always_comb begin
        state_d  = state_q;
        cmd_pop  = 1'b0;
        drop_evt = 1'b0;
        case (state_q)
            ST_IDLE:     if (!cmd_empty) state_d = ST_SEND;
            ST_SEND:     state_d = ST_WAIT_ACK;
            ST_WAIT_ACK: begin
                if (ack2controller) begin
                    cmd_pop = 1'b1;
                    state_d = ST_IDLE;
                end else if (timeout) begin
                    if (retry_left) begin
                        state_d = ST_SEND;
                    end else begin
                        cmd_pop  = 1'b1;
                        drop_evt = 1'b1;
                        state_d  = ST_IDLE;
                    end
                end
            end
            default:     state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q         <= ST_IDLE;
            timer_q         <= '0;
            retry_q         <= '0;
            ready_en        <= 1'b0;
            controller2daco <= '0;
            err_drop        <= 1'b0;
            drop_cnt        <= '0;
            ovf_cnt         <= '0;
        end else begin
            state_q  <= state_d;
            ready_en <= 1'b1;
            timer_q  <= (state_q == ST_WAIT_ACK) ? timer_q + 1'b1 : '0;

            if (cmd_pop)
                retry_q <= '0;
            else if (state_q == ST_WAIT_ACK && state_d == ST_SEND)
                retry_q <= retry_q + 1'b1;

            // Loaded on entry to SEND, so the pulse lasts exactly the SEND cycle.
            controller2daco <= (state_d == ST_SEND) ? (cmd_head | {1'b1, {(PKT_W-1){1'b0}}}) : '0;

            // A coincident event beats clr_err: the counter restarts at 1.
            if (drop_evt) begin
                err_drop <= 1'b1;
                drop_cnt <= clr_err ? 8'd1 : ((drop_cnt == 8'hFF) ? drop_cnt : drop_cnt + 8'd1);
            end else if (clr_err) begin
                err_drop <= 1'b0;
                drop_cnt <= '0;
            end

            if (ovf_evt)
                ovf_cnt <= clr_err ? 8'd1 : ((ovf_cnt == 8'hFF) ? ovf_cnt : ovf_cnt + 8'd1);
            else if (clr_err)
                ovf_cnt <= '0;
        end
    end

endmodule
